uncached_dm_bridge: RTL and testbench

Responder for the memory stage's uncached data-SRAM request interface (read/write/uncached/data_ok). Captures one uncached load or store, performs it as a single-beat AXI4 transaction on the uncached data port, and returns a one-cycle `data_sram_data_ok` with the read word. While it is busy, the memory stage stays stalled. Cached accesses bypass this block entirely.

---
 rtl/uncached_dm_bridge.sv | 212 +++++++++++++++++++++
 tb/tb_uncached_dm_bridge.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uncached_dm_bridge.sv
// uncached_dm_bridge: turns one uncached load/store from the memory stage
// into a single-beat AXI4 transaction and returns a one-cycle data_ok.
// A pipeline flush during a transaction lets the AXI side finish but
// suppresses the completion pulse and leaves the read-data register untouched.
module uncached_dm_bridge #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        ExceptionFlush,
  input  logic        read,
  input  logic        write,
  input  logic        uncached,
  input  logic [31:0] data_sram_addr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        data_sram_data_ok,
  output logic        busy,
  // AR channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  // R channel
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AW channel
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  // W channel
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // B channel
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WREQ  = 3'd3,
    WRESP = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t      state_reg, state_next;
  logic        discard_reg, discard_next;
  logic [31:0] addr_reg, addr_next;
  logic [1:0]  size_reg, size_next;
  logic [3:0]  wstrb_reg, wstrb_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [31:0] rdata_reg, rdata_next;
  logic        arvalid_reg, arvalid_next;
  logic        rready_reg, rready_next;
  logic        awvalid_reg, awvalid_next;
  logic        wvalid_reg, wvalid_next;
  logic        bready_reg, bready_next;

  // Response codes and rlast carry no information for single-beat,
  // error-tolerant accesses.
  logic unused_resp;
  assign unused_resp = &{1'b0, rresp, rlast, bresp};

  // Next-state, handshake tracking and capture of request/response data
  always_comb begin
    state_next   = state_reg;
    discard_next = discard_reg;
    addr_next    = addr_reg;
    size_next    = size_reg;
    wstrb_next   = wstrb_reg;
    wdata_next   = wdata_reg;
    rdata_next   = rdata_reg;
    arvalid_next = arvalid_reg;
    rready_next  = rready_reg;
    awvalid_next = awvalid_reg;
    wvalid_next  = wvalid_reg;
    bready_next  = bready_reg;

    // A flush mid-transaction only marks the result as unwanted.
    if (ExceptionFlush && state_reg != IDLE) discard_next = 1'b1;

    case (state_reg)
      IDLE: begin
        if ((read || write) && uncached && !ExceptionFlush) begin
          addr_next  = data_sram_addr;
          size_next  = data_sram_size;
          wstrb_next = data_sram_wstrb;
          wdata_next = data_sram_wdata;
          if (write) begin
            state_next   = WREQ;
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
          end else begin
            state_next   = RADDR;
            arvalid_next = 1'b1;
          end
        end
      end
      RADDR: begin
        if (arready) begin
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
          state_next   = RDATA;
        end
      end
      RDATA: begin
        if (rvalid) begin
          rready_next = 1'b0;
          state_next  = DONE;
          if (!discard_next) rdata_next = rdata;
        end
      end
      WREQ: begin
        // Address and data channels retire independently.
        awvalid_next = awvalid_reg && !awready;
        wvalid_next  = wvalid_reg && !wready;
        if (!awvalid_next && !wvalid_next) begin
          bready_next = 1'b1;
          state_next  = WRESP;
        end
      end
      WRESP: begin
        if (bvalid) begin
          bready_next = 1'b0;
          state_next  = DONE;
        end
      end
      DONE: begin
        state_next   = IDLE;
        discard_next = 1'b0;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      discard_reg <= 1'b0;
      addr_reg    <= 32'd0;
      size_reg    <= 2'd0;
      wstrb_reg   <= 4'd0;
      wdata_reg   <= 32'd0;
      rdata_reg   <= 32'd0;
      arvalid_reg <= 1'b0;
      rready_reg  <= 1'b0;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      bready_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      discard_reg <= discard_next;
      addr_reg    <= addr_next;
      size_reg    <= size_next;
      wstrb_reg   <= wstrb_next;
      wdata_reg   <= wdata_next;
      rdata_reg   <= rdata_next;
      arvalid_reg <= arvalid_next;
      rready_reg  <= rready_next;
      awvalid_reg <= awvalid_next;
      wvalid_reg  <= wvalid_next;
      bready_reg  <= bready_next;
    end
  end

  assign data_sram_rdata   = rdata_reg;
  assign data_sram_data_ok = (state_reg == DONE) && !discard_reg;
  assign busy              = (state_reg != IDLE);

  assign arid    = AXI_ID;
  assign araddr  = addr_reg;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, size_reg};
  assign arburst = 2'b01;
  assign arvalid = arvalid_reg;
  assign rready  = rready_reg;

  assign awid    = AXI_ID;
  assign awaddr  = addr_reg;
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, size_reg};
  assign awburst = 2'b01;
  assign awvalid = awvalid_reg;

  assign wdata   = wdata_reg;
  assign wstrb   = wstrb_reg;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_reg;
  assign bready  = bready_reg;

endmodule

// File: tb/tb_uncached_dm_bridge.sv
// tb_uncached_dm_bridge: drives random and directed uncached loads/stores
// through a small AXI slave model and checks handshake counts, address
// attributes, completion latency, flush discard and read-data hold.
module tb_uncached_dm_bridge;

  logic        Clk = 1'b0;
  logic        reset, ExceptionFlush, read, write, uncached;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic        data_sram_data_ok, busy;
  logic [3:0]  arid, awid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready;
  logic [3:0]  wstrb;
  logic        bvalid, bready;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model_rdata = 32'd0;

  uncached_dm_bridge #(.AXI_ID(4'd1)) dut (
    .Clk(Clk), .reset(reset), .ExceptionFlush(ExceptionFlush),
    .read(read), .write(write), .uncached(uncached),
    .data_sram_addr(data_sram_addr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata), .data_sram_data_ok(data_sram_data_ok),
    .busy(busy),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic slave_idle;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'd0;
  endtask

  task automatic host_idle;
    read = 1'b0; write = 1'b0; uncached = 1'b0; ExceptionFlush = 1'b0;
    data_sram_addr = 32'd0; data_sram_size = 2'd0;
    data_sram_wstrb = 4'd0; data_sram_wdata = 32'd0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arvalid"}, arvalid, 1'b0);
    check({tag, "_awvalid"}, awvalid, 1'b0);
    check({tag, "_wvalid"}, wvalid, 1'b0);
    check({tag, "_rready"}, rready, 1'b0);
    check({tag, "_bready"}, bready, 1'b0);
    check({tag, "_data_ok"}, data_sram_data_ok, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_rdata"}, data_sram_rdata, 32'd0);
    check({tag, "_araddr"}, araddr, 32'd0);
    check({tag, "_awaddr"}, awaddr, 32'd0);
    check({tag, "_wdata"}, wdata, 32'd0);
    check({tag, "_wstrb"}, wstrb, 4'd0);
    check({tag, "_arsize"}, arsize, 3'd0);
  endtask

  // One transaction: request presented in cycle 0, slave delays in cycles,
  // flush_cyc < 1 means no flush. Model: a transaction completes with exactly
  // one handshake per channel; data_ok appears once unless a flush was seen
  // before the final response beat completed.
  task automatic run_txn(input string name, input bit is_wr, input logic [31:0] addr,
                         input logic [1:0] sz, input logic [3:0] strb,
                         input logic [31:0] wd, input logic [31:0] sdata,
                         input int ar_d, input int r_d, input int aw_d,
                         input int w_d, input int b_d, input int flush_cyc);
    int cyc = 1;
    int ok_cnt = 0, ok_cyc = -1;
    int ar_hs = 0, r_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0;
    int ar_wait = 0, aw_wait = 0, w_wait = 0;
    int ar_cyc = -1, aw_cyc = -1, w_cyc = -1, both_cyc = -1;
    int exp_cyc;
    bit flushed = 1'b0, resp_done = 1'b0;
    logic [31:0] ok_data = 32'd0;

    check({name, "_idle_before"}, busy, 1'b0);
    read = !is_wr; write = is_wr; uncached = 1'b1;
    data_sram_addr = addr; data_sram_size = sz;
    data_sram_wstrb = strb; data_sram_wdata = wd;
    tick;
    host_idle();

    while (cyc < 80) begin
      ExceptionFlush = 1'b0; arready = 1'b0; awready = 1'b0; wready = 1'b0;
      if (data_sram_data_ok) begin
        ok_cnt++; ok_cyc = cyc; ok_data = data_sram_rdata;
      end
      if (!busy) break;
      if (cyc == flush_cyc && !resp_done) begin
        ExceptionFlush = 1'b1; flushed = 1'b1;
      end
      if (arvalid) begin
        check({name, "_araddr"}, araddr, addr);
        check({name, "_arsize"}, arsize, {1'b0, sz});
        if (ar_wait >= ar_d) begin arready = 1'b1; ar_hs++; ar_cyc = cyc; end
        else ar_wait++;
      end
      if (ar_cyc >= 0 && cyc > ar_cyc + r_d && r_hs == 0) begin
        rvalid = 1'b1; rdata = sdata; rlast = 1'b1; rresp = 2'($urandom_range(0, 3));
        if (rready) begin r_hs++; resp_done = 1'b1; end
      end else begin
        rvalid = 1'b0; rdata = 32'($urandom);
      end
      if (awvalid) begin
        check({name, "_awaddr"}, awaddr, addr);
        check({name, "_awsize"}, awsize, {1'b0, sz});
        if (aw_wait >= aw_d) begin awready = 1'b1; aw_hs++; aw_cyc = cyc; end
        else aw_wait++;
      end
      if (wvalid) begin
        check({name, "_wdata"}, wdata, wd);
        check({name, "_wstrb"}, wstrb, strb);
        check({name, "_wlast"}, wlast, 1'b1);
        if (w_wait >= w_d) begin wready = 1'b1; w_hs++; w_cyc = cyc; end
        else w_wait++;
      end
      if (both_cyc < 0 && aw_cyc >= 0 && w_cyc >= 0)
        both_cyc = (aw_cyc > w_cyc) ? aw_cyc : w_cyc;
      if (both_cyc >= 0 && cyc > both_cyc + b_d && b_hs == 0) begin
        bvalid = 1'b1; bresp = 2'($urandom_range(0, 3));
        if (bready) begin b_hs++; resp_done = 1'b1; end
      end else begin
        bvalid = 1'b0;
      end
      tick;
      cyc++;
    end
    slave_idle();
    ExceptionFlush = 1'b0;

    check({name, "_complete"}, busy, 1'b0);
    check({name, "_ar_hs"}, ar_hs, is_wr ? 0 : 1);
    check({name, "_r_hs"}, r_hs, is_wr ? 0 : 1);
    check({name, "_aw_hs"}, aw_hs, is_wr ? 1 : 0);
    check({name, "_w_hs"}, w_hs, is_wr ? 1 : 0);
    check({name, "_b_hs"}, b_hs, is_wr ? 1 : 0);
    check({name, "_ok_count"}, ok_cnt, flushed ? 0 : 1);
    if (!flushed) begin
      exp_cyc = is_wr ? 3 + ((aw_d > w_d) ? aw_d : w_d) + b_d : 3 + ar_d + r_d;
      check({name, "_latency"}, ok_cyc, exp_cyc);
      if (!is_wr) begin
        model_rdata = sdata;
        check({name, "_ok_rdata"}, ok_data, sdata);
      end
    end
    check({name, "_rdata_hold"}, data_sram_rdata, model_rdata);
    $display("[TB] %s %s addr=%h size=%0d flushed=%0d ok=%0d at cycle %0d",
             name, is_wr ? "store" : "load", addr, sz, flushed, ok_cnt, ok_cyc);
  endtask

  initial begin
    host_idle();
    slave_idle();
    reset = 1'b1;
    tick; tick; tick;
    check_reset_outputs("reset");
    check("reset_arlen", arlen, 8'd0);
    check("reset_arburst", arburst, 2'b01);
    check("reset_awburst", awburst, 2'b01);
    check("reset_arid", arid, 4'd1);
    check("reset_awid", awid, 4'd1);
    reset = 1'b0;
    tick;

    // lw, zero-wait slave
    run_txn("lw_basic", 1'b0, 32'hBFC0_1004, 2'd2, 4'hF, 32'd0, 32'h1234_5678,
            0, 0, 0, 0, 0, -1);
    // sb with awready delayed 3 cycles
    run_txn("sb_awdelay", 1'b1, 32'hBFAF_8003, 2'd0, 4'b1000, 32'hAB00_0000, 32'd0,
            0, 0, 3, 0, 0, -1);
    // arready held low 5 cycles
    run_txn("lw_arstall", 1'b0, 32'hBFD0_0010, 2'd2, 4'hF, 32'd0, 32'hCAFE_F00D,
            5, 1, 0, 0, 0, -1);
    // flush while in RDATA: rdata must not change
    run_txn("lw_flush", 1'b0, 32'hBFD0_0020, 2'd2, 4'hF, 32'd0, 32'hDEAD_BEEF,
            0, 3, 0, 0, 0, 3);
    run_txn("lw_after_flush", 1'b0, 32'hBFD0_0024, 2'd1, 4'hF, 32'd0, 32'h0BAD_0001,
            0, 0, 0, 0, 0, -1);

    // cached read held high: no activity
    read = 1'b1; uncached = 1'b0; data_sram_addr = 32'h8000_0000;
    for (int i = 0; i < 6; i++) begin
      tick;
      check("cached_busy", busy, 1'b0);
      check("cached_arvalid", arvalid, 1'b0);
    end
    host_idle();
    $display("[TB] cached read ignored for 6 cycles");

    // request together with a flush in IDLE is not accepted
    read = 1'b1; uncached = 1'b1; ExceptionFlush = 1'b1; data_sram_addr = 32'hBFC0_0000;
    tick;
    host_idle();
    check("flush_idle_busy", busy, 1'b0);
    check("flush_idle_arvalid", arvalid, 1'b0);
    $display("[TB] request with flush in IDLE rejected");

    // two back-to-back loads to the same address
    run_txn("lw_same_a", 1'b0, 32'hBFC0_2000, 2'd2, 4'hF, 32'd0, 32'h1111_2222,
            0, 0, 0, 0, 0, -1);
    run_txn("lw_same_b", 1'b0, 32'hBFC0_2000, 2'd2, 4'hF, 32'd0, 32'h3333_4444,
            0, 0, 0, 0, 0, -1);

    // reset asserted while waiting for the write response
    write = 1'b1; uncached = 1'b1; data_sram_addr = 32'hBFAF_0000;
    data_sram_wdata = 32'h5555_AAAA; data_sram_wstrb = 4'hF; data_sram_size = 2'd2;
    tick;
    host_idle();
    awready = 1'b1; wready = 1'b1;
    for (int i = 0; i < 10 && !bready; i++) begin
      tick;
      awready = 1'b0; wready = 1'b0;
    end
    slave_idle();
    check("wresp_reached", bready, 1'b1);
    reset = 1'b1;
    tick;
    model_rdata = 32'd0;
    check_reset_outputs("reset_wresp");
    reset = 1'b0;
    $display("[TB] reset during write response wait");
    tick;

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      bit          w = 1'($urandom_range(0, 1));
      logic [1:0]  sz = 2'($urandom_range(0, 2));
      int          fc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : -1;
      run_txn($sformatf("rand%0d", t), w, $urandom, sz, 4'($urandom), $urandom, $urandom,
              int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 4)), fc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
